// File: rtl/fifo_rr_controller.sv
// fifo_rr_controller
//   Write-side arbiter and read-side sequencer for a shared FIFO whose write
//   and read clocks are both tied to clk. Two requesters share the FIFO write
//   port under burst-limited round-robin. The read side turns the FIFO's
//   empty/increment pair into a registered valid/ready output stream.
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   req0_valid/data/ready       requester 0 (APB TX path)
//   req1_valid/data/ready       requester 1 (I2C RX path)
//   grant                       one-hot registered owner, 2'b00 = idle
//   fifo_write_data/increment   to FIFO write port
//   fifo_write_full             from FIFO
//   fifo_read_data/empty        from FIFO (read_data is combinational)
//   fifo_read_increment         to FIFO read port
//   out_valid/out_data          registered output word
//   out_ready                   consumer accept
module fifo_rr_controller #(
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [DATA_SIZE-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DATA_SIZE-1:0] req1_data,
    output logic                 req1_ready,
    output logic [1:0]           grant,
    output logic [DATA_SIZE-1:0] fifo_write_data,
    output logic                 fifo_write_increment,
    input  logic                 fifo_write_full,
    input  logic [DATA_SIZE-1:0] fifo_read_data,
    input  logic                 fifo_read_empty,
    output logic                 fifo_read_increment,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data,
    input  logic                 out_ready
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t     state, state_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic       last, last_nxt;     // index of the most recent owner

    // Owner-relative view so GRANT0 and GRANT1 share one body.
    logic   own;
    logic   own_valid, oth_valid, xfer;
    state_t other;

    assign own       = (state == GRANT1);
    assign own_valid = own ? req1_valid : req0_valid;
    assign oth_valid = own ? req0_valid : req1_valid;
    assign other     = own ? GRANT0 : GRANT1;
    assign xfer      = (state != IDLE) && own_valid && !fifo_write_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            last      <= 1'b1;
            grant     <= 2'b00;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            last      <= last_nxt;
            grant     <= {state_nxt == GRANT1, state_nxt == GRANT0};
        end
    end

    always_comb begin
        state_nxt            = state;
        burst_nxt            = burst_cnt;
        last_nxt             = last;
        req0_ready           = 1'b0;
        req1_ready           = 1'b0;
        fifo_write_data      = '0;
        fifo_write_increment = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid)
                    state_nxt = last ? GRANT0 : GRANT1;
                else if (req0_valid)
                    state_nxt = GRANT0;
                else if (req1_valid)
                    state_nxt = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (own) req1_ready = !fifo_write_full;
                else     req0_ready = !fifo_write_full;
                fifo_write_data      = own ? req1_data : req0_data;
                fifo_write_increment = xfer;
                if (!own_valid) begin
                    // Owner went quiet: hand over or drop to idle.
                    state_nxt = oth_valid ? other : IDLE;
                    burst_nxt = '0;
                    last_nxt  = own;
                end else if (xfer && burst_cnt == BURST_LAST) begin
                    // Burst exhausted; only yield if someone is waiting.
                    burst_nxt = '0;
                    if (oth_valid) begin
                        state_nxt = other;
                        last_nxt  = own;
                    end
                end else if (xfer) begin
                    burst_nxt = burst_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read side: refill the output register whenever it is empty or being
    // drained this cycle, giving one word per cycle under steady ready.
    logic load;
    assign load                = !fifo_read_empty && (!out_valid || out_ready);
    assign fifo_read_increment = load;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= fifo_read_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rr_controller.sv
// tb_fifo_rr_controller
//   Directed bench for fifo_rr_controller with a behavioural 256-deep FIFO
//   (2-flop write-pointer synchronizer on the empty flag) and queue-backed
//   requesters that hold valid/data until accepted.
module tb_fifo_rr_controller;

    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic [1:0]    grant;
    logic [DW-1:0] fifo_write_data;
    logic          fifo_write_increment;
    logic          fifo_write_full;
    logic [DW-1:0] fifo_read_data;
    logic          fifo_read_empty;
    logic          fifo_read_increment;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    always #5 clk = ~clk;

    fifo_rr_controller #(.DATA_SIZE(DW), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .grant(grant),
        .fifo_write_data(fifo_write_data), .fifo_write_increment(fifo_write_increment),
        .fifo_write_full(fifo_write_full),
        .fifo_read_data(fifo_read_data), .fifo_read_empty(fifo_read_empty),
        .fifo_read_increment(fifo_read_increment),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    // Behavioural FIFO model
    logic [DW-1:0] mem [DEPTH];
    logic [8:0]    wptr, rptr, ws1, ws2;

    always @(posedge clk) begin
        if (reset) begin
            wptr <= '0; rptr <= '0; ws1 <= '0; ws2 <= '0;
        end else begin
            if (fifo_write_increment && !fifo_write_full) begin
                mem[wptr[7:0]] <= fifo_write_data;
                wptr <= wptr + 9'd1;
            end
            if (fifo_read_increment && !fifo_read_empty)
                rptr <= rptr + 9'd1;
            ws1 <= wptr;
            ws2 <= ws1;
        end
    end

    assign fifo_write_full = (wptr[8] != rptr[8]) && (wptr[7:0] == rptr[7:0]);
    assign fifo_read_empty = (rptr == ws2);
    assign fifo_read_data  = mem[rptr[7:0]];

    // Bench state
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] q0[$], q1[$], olog[$];
    int            wlog[$];
    int            both_rdy;
    logic          en0, en1;
    logic          last_wr;
    logic [1:0]    last_grant;

    task automatic drive_reqs();
        req0_valid = en0 && (q0.size() > 0);
        req0_data  = (q0.size() > 0) ? q0[0] : '0;
        req1_valid = en1 && (q1.size() > 0);
        req1_data  = (q1.size() > 0) ? q1[0] : '0;
    endtask

    // One clock: sample handshakes mid-cycle, then advance requesters.
    task automatic cycle();
        logic a0, a1;
        @(negedge clk);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        if (req0_ready && req1_ready) both_rdy++;
        last_wr    = fifo_write_increment;
        last_grant = grant;
        if (fifo_write_increment && !reset) wlog.push_back(a1 ? 1 : 0);
        if (out_valid && out_ready && !reset) olog.push_back(out_data);
        @(posedge clk);
        #1;
        if (a0 && !reset && q0.size() > 0) void'(q0.pop_front());
        if (a1 && !reset && q1.size() > 0) void'(q1.pop_front());
        drive_reqs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en0 = 1'b0; en1 = 1'b0;
        q0.delete(); q1.delete();
        drive_reqs();
        out_ready = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        olog.delete(); wlog.delete();
        both_rdy = 0;
    endtask

    task automatic run_out(input int n, input int budget, input string name);
        while (olog.size() < n && budget > 0) begin
            cycle();
            budget--;
        end
        checks++;
        if (olog.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d words, want %0d", name, olog.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        cycle();
        checks++;
        if (grant !== 2'b00 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_arb: grant=%b r0=%b r1=%b want 00/0/0", grant, req0_ready, req1_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: valid=%b data=%h want 0/00", out_valid, out_data);
        end
        checks++;
        if (fifo_write_increment !== 1'b0) begin
            errors++;
            $display("FAIL reset_winc: got %b want 0", fifo_write_increment);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [DW-1:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        do_reset();
        out_ready = 1'b1;
        en0 = 1'b1;
        for (int i = 0; i < 3; i++) q0.push_back(exp[i]);
        drive_reqs();
        #1;
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL single_wait: grant=%b want 00", grant);
        end
        cycle();
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: grant=%b want 01", grant);
        end
        run_out(3, 50, "single_out");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= olog.size() || olog[i] !== exp[i]) begin
                errors++;
                $display("FAIL single_data[%0d]: got %h want %h", i,
                         (i < olog.size()) ? olog[i] : 8'hxx, exp[i]);
            end
        end
        repeat (4) cycle();
        checks++;
        if (fifo_read_empty !== 1'b1) begin
            errors++;
            $display("FAIL single_empty: got %b want 1", fifo_read_empty);
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp [16];
        do_reset();
        out_ready = 1'b1;
        en0 = 1'b1; en1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q0.push_back(8'hA0 + 8'(i));
            q1.push_back(8'hB0 + 8'(i));
        end
        drive_reqs();
        // req0 first after reset, bursts of 4 alternating
        for (int i = 0; i < 16; i++)
            exp[i] = ((i / 4) % 2 == 0) ? (8'hA0 + 8'((i / 8) * 4 + i % 4))
                                        : (8'hB0 + 8'((i / 8) * 4 + i % 4));
        run_out(16, 100, "rr_out");
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= olog.size() || olog[i] !== exp[i]) begin
                errors++;
                $display("FAIL rr_data[%0d]: got %h want %h", i,
                         (i < olog.size()) ? olog[i] : 8'hxx, exp[i]);
            end
            checks++;
            if (i >= wlog.size() || wlog[i] != (i / 4) % 2) begin
                errors++;
                $display("FAIL rr_owner[%0d]: got %0d want %0d", i,
                         (i < wlog.size()) ? wlog[i] : -1, (i / 4) % 2);
            end
        end
        checks++;
        if (both_rdy != 0) begin
            errors++;
            $display("FAIL rr_both_ready: got %0d cycles want 0", both_rdy);
        end
    endtask

    task automatic test_full();
        int budget;
        int bad;
        do_reset();
        out_ready = 1'b0;
        en0 = 1'b1;
        for (int i = 0; i < 260; i++) q0.push_back(8'(i));
        drive_reqs();
        budget = 600;
        while (!fifo_write_full && budget > 0) begin
            cycle();
            budget--;
        end
        checks++;
        if (fifo_write_full !== 1'b1) begin
            errors++;
            $display("FAIL full_reach: write_full=%b want 1", fifo_write_full);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (req0_ready !== 1'b0 || grant !== 2'b01 || fifo_write_increment !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_hold: %0d bad cycles want 0 (r0=%b grant=%b winc=%b)",
                     bad, req0_ready, grant, fifo_write_increment);
        end
        out_ready = 1'b1;
        run_out(260, 3000, "full_drain");
        bad = 0;
        for (int i = 0; i < 260; i++)
            if (i >= olog.size() || olog[i] !== 8'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_readback: %0d wrong words want 0", bad);
        end
    endtask

    task automatic test_single_stream();
        int first, lastc, wr_cnt, cyc;
        do_reset();
        out_ready = 1'b1;
        en1 = 1'b1;
        for (int i = 0; i < 10; i++) q1.push_back(8'hC0 + 8'(i));
        drive_reqs();
        first = -1; lastc = -1; wr_cnt = 0; cyc = 0;
        while (wr_cnt < 10 && cyc < 60) begin
            cycle();
            if (last_wr) begin
                if (first < 0) first = cyc;
                lastc = cyc;
                wr_cnt++;
                if (last_grant !== 2'b10) first = -1000;
            end
            cyc++;
        end
        checks++;
        if (wr_cnt != 10 || first < 0 || lastc - first != 9) begin
            errors++;
            $display("FAIL stream_bubbles: writes=%0d span=%0d want 10/9", wr_cnt, lastc - first);
        end
        run_out(10, 50, "stream_out");
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= olog.size() || olog[i] !== 8'hC0 + 8'(i)) begin
                errors++;
                $display("FAIL stream_data[%0d]: got %h want %h", i,
                         (i < olog.size()) ? olog[i] : 8'hxx, 8'hC0 + 8'(i));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        en0 = 1'b1;
        q0.push_back(8'hA1); q0.push_back(8'hA2); q0.push_back(8'hA3);
        drive_reqs();
        repeat (10) cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA1 || fifo_read_increment !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold1: v=%b d=%h inc=%b want 1/a1/0", out_valid, out_data, fifo_read_increment);
        end
        cycle();
        checks++;
        if (out_data !== 8'hA1) begin
            errors++;
            $display("FAIL stall_stable: got %h want a1", out_data);
        end
        out_ready = 1'b1; #1;
        checks++;
        if (fifo_read_increment !== 1'b1) begin
            errors++;
            $display("FAIL stall_load1: inc=%b want 1", fifo_read_increment);
        end
        cycle();
        out_ready = 1'b0; #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA2 || fifo_read_increment !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold2: v=%b d=%h inc=%b want 1/a2/0", out_valid, out_data, fifo_read_increment);
        end
        cycle();
        out_ready = 1'b1; #1;
        checks++;
        if (out_data !== 8'hA2 || fifo_read_increment !== 1'b1) begin
            errors++;
            $display("FAIL stall_load2: d=%h inc=%b want a2/1", out_data, fifo_read_increment);
        end
        cycle();
        out_ready = 1'b0; #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA3 || fifo_read_increment !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold3: v=%b d=%h inc=%b want 1/a3/0", out_valid, out_data, fifo_read_increment);
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: v=%b want 0", out_valid);
        end
        checks++;
        if (olog.size() != 3 || olog[0] !== 8'hA1 || olog[1] !== 8'hA2 || olog[2] !== 8'hA3) begin
            errors++;
            $display("FAIL stall_order: got %0d words want a1,a2,a3", olog.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        out_ready = 1'b1;
        en0 = 1'b1;
        for (int i = 0; i < 8; i++) q0.push_back(8'h60 + 8'(i));
        drive_reqs();
        repeat (5) cycle();
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL midrst_pre: grant=%b want 01", grant);
        end
        reset = 1'b1;
        en0 = 1'b0;
        q0.delete();
        drive_reqs();
        cycle();
        checks++;
        if (grant !== 2'b00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: grant=%b v=%b want 00/0", grant, out_valid);
        end
        reset = 1'b0;
        olog.delete();
        en1 = 1'b1;
        q1.push_back(8'h5A);
        drive_reqs();
        run_out(1, 50, "midrst_out");
        checks++;
        if (olog.size() < 1 || olog[0] !== 8'h5A) begin
            errors++;
            $display("FAIL midrst_first: got %h want 5a", (olog.size() > 0) ? olog[0] : 8'hxx);
        end
    endtask

    initial begin
        reset = 1'b1;
        en0 = 1'b0; en1 = 1'b0;
        out_ready = 1'b0;
        both_rdy = 0;
        last_wr = 1'b0;
        last_grant = 2'b00;
        drive_reqs();
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_single_stream();
        test_stall();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
